// File: rtl/memory_data_register.sv
// MiniSRC memory data register: bus/memory source mux feeding a clear/enable register.
// Optional MDR_BUS_GATE_EN adds MDRout and the gated bus_q output.
module mdr_mux2 #(
   parameter int WIDTH = 32
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? b : a;

endmodule

module mdr_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // clear outranks the load enable on the same edge
   always_ff @(posedge clock) begin
      if (clear)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

module memory_data_register #(
   parameter int WIDTH = 32
) (
   input  logic             clear,
   input  logic             clock,
   input  logic             MDRin,
   input  logic [WIDTH-1:0] BusMuxOut,
   input  logic [WIDTH-1:0] Mdatain,
   input  logic             read,
`ifdef MDR_BUS_GATE_EN
   input  logic             MDRout,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] bus_q
`else
   output logic [WIDTH-1:0] q
`endif
);

   logic [WIDTH-1:0] d;

   mdr_mux2 #(.WIDTH(WIDTH)) u_mux (
      .sel (read),
      .a   (BusMuxOut),
      .b   (Mdatain),
      .y   (d)
   );

   mdr_reg #(.WIDTH(WIDTH)) u_reg (
      .clock (clock),
      .clear (clear),
      .en    (MDRin),
      .d     (d),
      .q     (q)
   );

`ifdef MDR_BUS_GATE_EN
   assign bus_q = MDRout ? q : '0;
`endif

endmodule

// File: tb/tb_memory_data_register.sv
// Self-checking bench for memory_data_register: directed plan plus random
// stimulus against a behavioural model of the MDR load/clear rules.
module tb_memory_data_register;

   localparam int W = 32;

   logic         clear;
   logic         clock;
   logic         MDRin;
   logic [W-1:0] BusMuxOut;
   logic [W-1:0] Mdatain;
   logic         read;
   logic [W-1:0] q;
`ifdef MDR_BUS_GATE_EN
   logic         MDRout;
   logic [W-1:0] bus_q;
`endif

   int checks = 0;
   int failures = 0;
   logic [W-1:0] exp_q;

   memory_data_register #(.WIDTH(W)) dut (
      .clear     (clear),
      .clock     (clock),
      .MDRin     (MDRin),
      .BusMuxOut (BusMuxOut),
      .Mdatain   (Mdatain),
      .read      (read),
`ifdef MDR_BUS_GATE_EN
      .MDRout    (MDRout),
      .q         (q),
      .bus_q     (bus_q)
`else
      .q         (q)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // model: what the register should hold after an edge with the current inputs
   task automatic model_edge();
      if (clear)
         exp_q = '0;
      else if (MDRin)
         exp_q = read ? Mdatain : BusMuxOut;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   initial begin
      clear = 1'b0;
      MDRin = 1'b0;
      read = 1'b0;
      BusMuxOut = '0;
      Mdatain = '0;
`ifdef MDR_BUS_GATE_EN
      MDRout = 1'b0;
`endif
      exp_q = '0;
      @(negedge clock);

      clear = 1'b1; MDRin = 1'b1; read = 1'b0;
      BusMuxOut = 32'hBEEFBEEF; Mdatain = 32'hFEEDFEED;
      tick();
      check("reset", q, 32'h0);

      clear = 1'b0;
      tick();
      check("bus_load", q, 32'hBEEFBEEF);

      read = 1'b1;
      tick();
      check("mem_load", q, 32'hFEEDFEED);

      MDRin = 1'b0; read = 1'b0; BusMuxOut = 32'h12345678;
      tick();
      check("hold1", q, 32'hFEEDFEED);
      read = 1'b1;
      tick();
      check("hold2", q, 32'hFEEDFEED);

      clear = 1'b1; MDRin = 1'b1; read = 1'b0;
      tick();
      check("clear_over_load", q, 32'h0);
      clear = 1'b0;
      tick();
      check("load_after_clear", q, 32'h12345678);

`ifdef MDR_BUS_GATE_EN
      BusMuxOut = 32'hBEEFBEEF;
      tick();
      MDRin = 1'b0;
      MDRout = 1'b0;
      #1;
      check("gate_off", bus_q, 32'h0);
      MDRout = 1'b1;
      #1;
      check("gate_on", bus_q, 32'hBEEFBEEF);
      check("gate_q", q, 32'hBEEFBEEF);
`endif

      for (int i = 0; i < 300; i++) begin
         clear = ($urandom_range(0, 9) == 0);
         MDRin = $urandom_range(0, 1);
         read = $urandom_range(0, 1);
         BusMuxOut = $urandom;
         Mdatain = $urandom;
`ifdef MDR_BUS_GATE_EN
         MDRout = $urandom_range(0, 1);
`endif
         #2;
         check("between_edges", q, exp_q);
`ifdef MDR_BUS_GATE_EN
         check("rand_gate", bus_q, MDRout ? exp_q : '0);
`endif
         // these values are the ones the next edge really sees
         BusMuxOut = $urandom;
         Mdatain = $urandom;
         read = $urandom_range(0, 1);
         tick();
         check("rand_q", q, exp_q);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
